// File: rtl/acc_pkg.sv
// Shared constants, state encoding and sizing helper for the chunk accumulator / splitter pair.
package acc_pkg;

  localparam int unsigned NB_TOTAL  = 6;
  localparam int unsigned NB_CHUNK  = 3;
  localparam int unsigned NB_CNT    = 4;
  localparam int unsigned CHUNK_MAX = (1 << NB_CHUNK) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Worst-case beats needed to emit a full-scale total: ceil((2**nt-1)/(2**nc-1)).
  function automatic int unsigned beat_bound(input int unsigned nt, input int unsigned nc);
    int unsigned tmax;
    int unsigned cmax;
    tmax = (1 << nt) - 1;
    cmax = (1 << nc) - 1;
    return (tmax + cmax - 1) / cmax;
  endfunction

  localparam int unsigned BEAT_MAX = beat_bound(NB_TOTAL, NB_CHUNK);

endpackage

// File: rtl/acc_chunk_min.sv
// Combinational chunk selection: chunk_c = min(remaining, CHUNK_MAX),
// fits_c = remaining already fits in one chunk (i.e. this would be the last beat).
// Ports:
//   remaining  in   NB_TOTAL  amount still to be emitted
//   chunk_c    out  NB_CHUNK  chunk to emit for this remaining value
//   fits_c     out  1         remaining <= CHUNK_MAX
module acc_chunk_min
  import acc_pkg::*;
(
  input  logic [NB_TOTAL-1:0] remaining,
  output logic [NB_CHUNK-1:0] chunk_c,
  output logic                fits_c
);

  always_comb begin
    fits_c  = (remaining <= NB_TOTAL'(CHUNK_MAX));
    chunk_c = fits_c ? remaining[NB_CHUNK-1:0] : NB_CHUNK'(CHUNK_MAX);
  end

endmodule

// File: rtl/acc_splitter.sv
// Splits a NB_TOTAL-bit total into a valid/ready stream of NB_CHUNK-bit chunks
// (each <= CHUNK_MAX) that sum back to the total.
// Optional macro ACC_SPLITTER_CHECK_EN adds a shadow sum of accepted chunks that
// raises o_err at the end of a job if it disagrees with the latched total.
// Ports:
//   clk, i_rst            clock, asynchronous active-high reset
//   i_start, i_total      job request (honoured only in IDLE) and value to split
//   i_ready               downstream accepts o_chunk this cycle
//   o_valid/o_chunk/o_last  chunk stream, o_last marks the final chunk
//   o_busy                high in SEND and DONE
//   o_done                one-cycle end-of-job pulse
//   o_count               beats accepted in the current or last job
//   o_err                 self-check mismatch (0 when the check is not built)
module acc_splitter
  import acc_pkg::*;
(
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_TOTAL-1:0] i_total,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [NB_CHUNK-1:0] o_chunk,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_CNT-1:0]   o_count,
  output logic                o_err
);

  state_t              state_q, state_d;
  logic [NB_TOTAL-1:0] remaining_q, remaining_d;
  logic                valid_q, valid_d;
  logic [NB_CHUNK-1:0] chunk_q, chunk_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NB_CNT-1:0]   count_q, count_d;

  logic                accept_c;
  logic                start_c;
  logic [NB_CHUNK-1:0] nxt_chunk_c;
  logic                nxt_fits_c;

  // Next-state, remaining and beat count.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    start_c     = 1'b0;
    accept_c    = valid_q & i_ready;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          start_c     = 1'b1;
          remaining_d = i_total;
          count_d     = '0;
          state_d     = (i_total != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (accept_c) begin
          // chunk_q never exceeds remaining_q, so this cannot underflow.
          remaining_d = remaining_q - NB_TOTAL'(chunk_q);
          count_d     = count_q + NB_CNT'(1);
          if (remaining_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  acc_chunk_min u_chunk_min (
    .remaining (remaining_d),
    .chunk_c   (nxt_chunk_c),
    .fits_c    (nxt_fits_c)
  );

  // Outputs are registered from next-state values; during backpressure remaining is
  // unchanged, so chunk/last stay stable.
  always_comb begin
    valid_d = (state_d == SEND);
    chunk_d = valid_d ? nxt_chunk_c : '0;
    last_d  = valid_d & nxt_fits_c;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      chunk_q     <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      chunk_q     <= chunk_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign o_valid = valid_q;
  assign o_chunk = chunk_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_count = count_q;

`ifdef ACC_SPLITTER_CHECK_EN
  // Shadow sum of accepted chunks, one bit wider than the total to catch overshoot.
  logic [NB_TOTAL:0]   shadow_q, shadow_d;
  logic [NB_TOTAL-1:0] total_q, total_d;
  logic                err_q, err_d;

  always_comb begin
    shadow_d = shadow_q;
    total_d  = total_q;
    err_d    = err_q;
    if (start_c) begin
      shadow_d = '0;
      total_d  = i_total;
      err_d    = 1'b0;
    end else if (state_q == SEND && accept_c) begin
      shadow_d = shadow_q + (NB_TOTAL + 1)'(chunk_q);
    end else if (state_q == DONE) begin
      err_d = (shadow_q != {1'b0, total_q});
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_q <= '0;
      total_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      total_q  <= total_d;
      err_q    <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_splitter.sv
// Directed bench for acc_splitter: drives and samples on the falling edge.
module tb_acc_splitter;
  import acc_pkg::*;

  logic                clk;
  logic                i_rst;
  logic                i_start;
  logic [NB_TOTAL-1:0] i_total;
  logic                i_ready;
  logic                o_valid;
  logic [NB_CHUNK-1:0] o_chunk;
  logic                o_last;
  logic                o_busy;
  logic                o_done;
  logic [NB_CNT-1:0]   o_count;
  logic                o_err;

  int passed = 0;
  int total  = 0;

  acc_splitter dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_total (i_total),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_chunk (o_chunk),
    .o_last  (o_last),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_count (o_count),
    .o_err   (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input int chunk, input bit last, input int cnt);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".chunk"}, 32'(o_chunk), 32'(chunk));
    chk({tag, ".last"},  32'(o_last),  32'(last));
    chk({tag, ".count"}, 32'(o_count), 32'(cnt));
    chk({tag, ".done"},  32'(o_done),  32'd0);
  endtask

  task automatic chk_done(input string tag, input int cnt);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".done"},  32'(o_done),  32'd1);
    chk({tag, ".busy"},  32'(o_busy),  32'd1);
    chk({tag, ".count"}, 32'(o_count), 32'(cnt));
  endtask

  task automatic chk_idle(input string tag, input int cnt);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".done"},  32'(o_done),  32'd0);
    chk({tag, ".busy"},  32'(o_busy),  32'd0);
    chk({tag, ".count"}, 32'(o_count), 32'(cnt));
    chk({tag, ".err"},   32'(o_err),   32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".chunk"}, 32'(o_chunk), 32'd0);
    chk({tag, ".last"},  32'(o_last),  32'd0);
    chk({tag, ".busy"},  32'(o_busy),  32'd0);
    chk({tag, ".done"},  32'(o_done),  32'd0);
    chk({tag, ".count"}, 32'(o_count), 32'd0);
    chk({tag, ".err"},   32'(o_err),   32'd0);
  endtask

  task automatic start_job(input int tot);
    i_start = 1'b1;
    i_total = NB_TOTAL'(tot);
    step();
    i_start = 1'b0;
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_total = '0;
    i_ready = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    i_rst = 1'b0;
    step();

    // 1: 20 -> 7,7,6
    start_job(20);
    chk_beat("t1.b0", 7, 1'b0, 0);
    step();
    chk_beat("t1.b1", 7, 1'b0, 1);
    step();
    chk_beat("t1.b2", 6, 1'b1, 2);
    step();
    chk_done("t1.done", 3);
    step();
    chk_idle("t1.idle", 3);

    // 2: zero total emits no beats
    start_job(0);
    chk_done("t2.done", 0);
    step();
    chk_idle("t2.idle", 0);

    // 3: full scale, nine beats of 7
    start_job(63);
    for (int i = 0; i < 9; i++) begin
      chk_beat($sformatf("t3.b%0d", i), 7, (i == 8), i);
      step();
    end
    chk_done("t3.done", 9);
    step();
    chk_idle("t3.idle", 9);

    // 4: backpressure on the first beat
    i_ready = 1'b0;
    start_job(10);
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("t4.hold%0d", i), 7, 1'b0, 0);
      step();
    end
    chk_beat("t4.b0", 7, 1'b0, 0);
    i_ready = 1'b1;
    step();
    chk_beat("t4.b1", 3, 1'b1, 1);
    step();
    chk_done("t4.done", 2);
    step();
    chk_idle("t4.idle", 2);

    // 5: reset mid-job, then a fresh job
    start_job(50);
    chk_beat("t5.b0", 7, 1'b0, 0);
    step();
    chk_beat("t5.b1", 7, 1'b0, 1);
    step();
    chk_beat("t5.b2", 7, 1'b0, 2);
    i_rst = 1'b1;
    step();
    chk_all_zero("t5.rst");
    i_rst = 1'b0;
    step();
    chk_all_zero("t5.after");
    start_job(5);
    chk_beat("t5.new", 5, 1'b1, 0);
    step();
    chk_done("t5.done", 1);
    step();
    chk_idle("t5.idle", 1);

    // 6: start during SEND is ignored
    start_job(20);
    chk_beat("t6.b0", 7, 1'b0, 0);
    i_start = 1'b1;
    i_total = NB_TOTAL'(3);
    step();
    chk_beat("t6.b1", 7, 1'b0, 1);
    step();
    chk_beat("t6.b2", 6, 1'b1, 2);
    i_start = 1'b0;
    step();
    chk_done("t6.done", 3);
    step();
    chk_idle("t6.idle", 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
